// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing the single-ported ECC register file between the
// Wishbone slave path and the logic-analyzer register port, with a ready timeout.
module regfile_access_arbiter #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned REGDIRSIZE     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_valid_i,
    input  logic                  wb_we_i,
    input  logic [REGDIRSIZE-1:0] wb_addr_i,
    input  logic [WORD_SIZE-1:0]  wb_wdata_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [WORD_SIZE-1:0]  wb_rdata_o,
    input  logic                  la_req_i,
    input  logic                  la_we_i,
    input  logic [REGDIRSIZE-1:0] la_addr_i,
    input  logic [WORD_SIZE-1:0]  la_wdata_i,
    output logic                  la_done_o,
    output logic                  la_err_o,
    output logic [WORD_SIZE-1:0]  la_rdata_o,
    output logic                  rf_req_o,
    output logic                  rf_we_o,
    output logic [REGDIRSIZE-1:0] rf_addr_o,
    output logic [WORD_SIZE-1:0]  rf_wdata_o,
    input  logic                  rf_ready_i,
    input  logic [WORD_SIZE-1:0]  rf_rdata_i,
    input  logic                  rf_err_i,
    output logic                  grant_o,
    output logic                  busy_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StWait, StWbResp, StLaHold} state_e;

    state_e                state_q;
    logic                  last_q;
    logic                  grant_q;
    logic                  rf_req_q;
    logic                  rf_we_q;
    logic [REGDIRSIZE-1:0] rf_addr_q;
    logic [WORD_SIZE-1:0]  rf_wdata_q;
    logic [CntW-1:0]       cnt_q;
    logic [WORD_SIZE-1:0]  cap_q;
    logic                  wb_ack_q;
    logic                  wb_err_q;
    logic [WORD_SIZE-1:0]  wb_rdata_q;
    logic                  wb_hold_q;
    logic                  wb_abort_q;
    logic                  la_done_q;
    logic                  la_err_q;
    logic [WORD_SIZE-1:0]  la_rdata_q;

    logic                  wb_req;
    logic                  pick_la;
    logic                  timeout;
    logic                  resp_err;
    logic [WORD_SIZE-1:0]  resp_data;

    always_comb begin
        // wb_hold_q masks the cycle right after an ack so a late stb drop is honoured
        wb_req    = wb_valid_i & ~wb_hold_q;
        pick_la   = (wb_req & la_req_i) ? ~last_q : la_req_i;
        timeout   = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
        resp_err  = rf_ready_i ? rf_err_i : 1'b1;
        resp_data = (rf_ready_i && !rf_we_q) ? rf_rdata_i : cap_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            grant_q    <= 1'b0;
            rf_req_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            cnt_q      <= '0;
            cap_q      <= '0;
            wb_ack_q   <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_rdata_q <= '0;
            wb_hold_q  <= 1'b0;
            wb_abort_q <= 1'b0;
            la_done_q  <= 1'b0;
            la_err_q   <= 1'b0;
            la_rdata_q <= '0;
        end else begin
            wb_ack_q  <= 1'b0;
            wb_err_q  <= 1'b0;
            wb_hold_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wb_req || la_req_i) begin
                        grant_q    <= pick_la;
                        last_q     <= pick_la;
                        rf_req_q   <= 1'b1;
                        rf_we_q    <= pick_la ? la_we_i : wb_we_i;
                        rf_addr_q  <= pick_la ? la_addr_i : wb_addr_i;
                        rf_wdata_q <= pick_la ? la_wdata_i : wb_wdata_i;
                        cnt_q      <= '0;
                        wb_abort_q <= 1'b0;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (!grant_q && !wb_valid_i) wb_abort_q <= 1'b1;
                    // ready takes priority over a coincident timeout
                    if (rf_ready_i || timeout) begin
                        rf_req_q <= 1'b0;
                        cap_q    <= resp_data;
                        if (grant_q) begin
                            la_done_q <= 1'b1;
                            la_err_q  <= resp_err;
                            if (rf_ready_i && !rf_we_q) la_rdata_q <= rf_rdata_i;
                            state_q <= StLaHold;
                        end else if (wb_abort_q || !wb_valid_i) begin
                            state_q <= StIdle;
                        end else begin
                            wb_ack_q   <= 1'b1;
                            wb_err_q   <= resp_err;
                            wb_rdata_q <= rf_we_q ? '0 : resp_data;
                            state_q    <= StWbResp;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWbResp: begin
                    wb_rdata_q <= '0;
                    wb_hold_q  <= 1'b1;
                    state_q    <= StIdle;
                end
                StLaHold: begin
                    if (!la_req_i) begin
                        la_done_q <= 1'b0;
                        la_err_q  <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_ack_o   = wb_ack_q;
    assign wb_err_o   = wb_err_q;
    assign wb_rdata_o = wb_rdata_q;
    assign la_done_o  = la_done_q;
    assign la_err_o   = la_err_q;
    assign la_rdata_o = la_rdata_q;
    assign rf_req_o   = rf_req_q;
    assign rf_we_o    = rf_we_q;
    assign rf_addr_o  = rf_addr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Scenario bench for regfile_access_arbiter: expected responses are queued when a
// request is driven and checked when the matching ack/done appears.
module tb_regfile_access_arbiter;
    localparam int W = 32;
    localparam int A = 5;

    typedef struct {
        logic          is_la;
        logic          err;
        logic          chk_data;
        logic [W-1:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic wb_valid_i = 0, wb_we_i = 0, la_req_i = 0, la_we_i = 0;
    logic [A-1:0] wb_addr_i = '0, la_addr_i = '0;
    logic [W-1:0] wb_wdata_i = '0, la_wdata_i = '0;
    logic wb_ack_o, wb_err_o, la_done_o, la_err_o;
    logic [W-1:0] wb_rdata_o, la_rdata_o, rf_wdata_o;
    logic rf_req_o, rf_we_o, grant_o, busy_o;
    logic [A-1:0] rf_addr_o;
    logic rf_ready_i = 0, rf_err_i = 0;
    logic [W-1:0] rf_rdata_i = '0;

    int n_checks = 0;
    int n_pass = 0;
    exp_t exp_q[$];

    // register-file model: ready in the rf_lat-th cycle of a request (0 = never)
    int rf_lat = 0;
    int rf_cnt = 0;
    logic [W-1:0] rf_data_cfg = '0;
    logic rf_err_cfg = 1'b0;

    regfile_access_arbiter #(
        .WORD_SIZE(W), .REGDIRSIZE(A), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wb_valid_i(wb_valid_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i),
        .wb_wdata_i(wb_wdata_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .wb_rdata_o(wb_rdata_o),
        .la_req_i(la_req_i), .la_we_i(la_we_i), .la_addr_i(la_addr_i),
        .la_wdata_i(la_wdata_i), .la_done_o(la_done_o), .la_err_o(la_err_o),
        .la_rdata_o(la_rdata_o),
        .rf_req_o(rf_req_o), .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o),
        .rf_wdata_o(rf_wdata_o), .rf_ready_i(rf_ready_i), .rf_rdata_i(rf_rdata_i),
        .rf_err_i(rf_err_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (rf_req_o) begin
                rf_cnt++;
                rf_ready_i = (rf_lat != 0 && rf_cnt == rf_lat);
            end else begin
                rf_cnt = 0;
                rf_ready_i = 1'b0;
            end
            rf_rdata_i = rf_ready_i ? rf_data_cfg : '0;
            rf_err_i = rf_ready_i & rf_err_cfg;
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        wb_valid_i = 0; la_req_i = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({rf_req_o, busy_o, wb_ack_o, wb_err_o, la_done_o, la_err_o, grant_o, rf_we_o}
            !== 8'h00)
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {rf_req_o, busy_o, wb_ack_o, wb_err_o, la_done_o, la_err_o, grant_o, rf_we_o});
        else n_pass++;
        n_checks++;
        if ({rf_addr_o, rf_wdata_o, wb_rdata_o, la_rdata_o} !== '0)
            $display("FAIL reset_data: got %h want 0",
                     {rf_addr_o, rf_wdata_o, wb_rdata_o, la_rdata_o});
        else n_pass++;
    endtask

    task automatic test_wb_write();
        int req_n = 0, bad = 0, t = 0;
        bit got = 0;
        exp_t e;
        rf_lat = 3; rf_err_cfg = 0; rf_data_cfg = 32'hCAFEF00D;
        @(negedge clk);
        wb_valid_i = 1; wb_we_i = 1; wb_addr_i = 5; wb_wdata_i = 32'hDEADBEEF;
        exp_q.push_back('{is_la: 0, err: 0, chk_data: 1, data: '0});
        while (!got && t < 40) begin
            @(negedge clk); t++;
            if (rf_req_o) begin
                req_n++;
                if ({rf_we_o, rf_addr_o, rf_wdata_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) bad++;
            end
            if (wb_ack_o) begin
                got = 1;
                e = exp_q.pop_front();
                n_checks++;
                if ({wb_err_o, wb_rdata_o} !== {e.err, e.data})
                    $display("FAIL wb_write_resp: got err=%b rdata=%h want err=%b rdata=%h",
                             wb_err_o, wb_rdata_o, e.err, e.data);
                else n_pass++;
                wb_valid_i = 0;
            end
        end
        n_checks++;
        if (!got) $display("FAIL wb_write_ack: got no ack want ack within 40 cycles");
        else n_pass++;
        n_checks++;
        if (req_n !== 3) $display("FAIL wb_write_req_len: got %0d want 3", req_n);
        else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL wb_write_fields: got %0d bad cycles want 0", bad);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({wb_ack_o, busy_o} !== 2'b00)
            $display("FAIL wb_write_ack_once: got ack,busy=%b want 00", {wb_ack_o, busy_o});
        else n_pass++;
    endtask

    task automatic test_la_read();
        int t = 0, bad = 0, held = 0;
        exp_t e;
        rf_lat = 2; rf_err_cfg = 0; rf_data_cfg = 32'h12345678;
        @(negedge clk);
        la_req_i = 1; la_we_i = 0; la_addr_i = 7; la_wdata_i = 32'h0;
        exp_q.push_back('{is_la: 1, err: 0, chk_data: 1, data: 32'h12345678});
        while (!la_done_o && t < 40) begin
            @(negedge clk); t++;
            if (rf_req_o && {rf_we_o, rf_addr_o} !== {1'b0, 5'd7}) bad++;
        end
        n_checks++;
        if (!la_done_o) $display("FAIL la_read_done: got 0 want 1 within 40 cycles");
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if ({la_err_o, la_rdata_o} !== {e.err, e.data})
            $display("FAIL la_read_resp: got err=%b rdata=%h want err=%b rdata=%h",
                     la_err_o, la_rdata_o, e.err, e.data);
        else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL la_read_fields: got %0d bad cycles want 0", bad);
        else n_pass++;
        repeat (3) begin
            @(negedge clk);
            if (la_done_o && la_rdata_o === 32'h12345678) held++;
        end
        n_checks++;
        if (held !== 3) $display("FAIL la_read_hold: got %0d held cycles want 3", held);
        else n_pass++;
        la_req_i = 0;
        @(negedge clk);
        n_checks++;
        if ({la_done_o, busy_o, la_rdata_o} !== {2'b00, 32'h12345678})
            $display("FAIL la_read_release: got done,busy=%b rdata=%h want 00 12345678",
                     {la_done_o, busy_o}, la_rdata_o);
        else n_pass++;
    endtask

    task automatic test_tie();
        logic [A:0] seen [4];
        logic [A:0] want [4];
        int ng = 0, t = 0, resp = 0;
        bit prev = 0, rearm = 0;
        exp_t e;
        do_reset();
        rf_lat = 2; rf_err_cfg = 0; rf_data_cfg = 32'hA5A5A5A5;
        want[0] = {1'b0, 5'd1}; want[1] = {1'b1, 5'd2};
        want[2] = {1'b0, 5'd1}; want[3] = {1'b1, 5'd2};
        for (int i = 0; i < 4; i++) seen[i] = '1;
        @(negedge clk);
        wb_valid_i = 1; wb_we_i = 1; wb_addr_i = 1; wb_wdata_i = 32'h11;
        la_req_i = 1; la_we_i = 0; la_addr_i = 2;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{is_la: 0, err: 0, chk_data: 1, data: '0});
            exp_q.push_back('{is_la: 1, err: 0, chk_data: 1, data: 32'hA5A5A5A5});
        end
        while (resp < 4 && t < 200) begin
            @(negedge clk); t++;
            if (rf_req_o && !prev && ng < 4) begin
                seen[ng] = {grant_o, rf_addr_o};
                ng++;
            end
            prev = rf_req_o;
            if (wb_ack_o || (la_done_o && la_req_i)) begin
                e = exp_q.pop_front();
                resp++;
                n_checks++;
                if ({e.is_la, wb_ack_o ? {wb_err_o, wb_rdata_o} : {la_err_o, la_rdata_o}}
                    !== {!wb_ack_o, e.err, e.data})
                    $display("FAIL tie_resp%0d: got la=%b wb_err=%b la_err=%b data=%h want la=%b data=%h",
                             resp, !wb_ack_o, wb_err_o, la_err_o,
                             wb_ack_o ? wb_rdata_o : la_rdata_o, e.is_la, e.data);
                else n_pass++;
                if (wb_ack_o && resp == 3) wb_valid_i = 0;
                if (!wb_ack_o) begin
                    la_req_i = 0;
                    rearm = (resp == 2);
                end
            end else if (rearm && !la_done_o) begin
                la_req_i = 1;
                rearm = 0;
            end
        end
        la_req_i = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (seen[i] !== want[i])
                $display("FAIL tie_grant%0d: got grant/addr=%h want %h", i, seen[i], want[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int req_n = 0, t = 0;
        bit got = 0;
        exp_t e;
        rf_lat = 0;
        @(negedge clk);
        wb_valid_i = 1; wb_we_i = 0; wb_addr_i = 9;
        exp_q.push_back('{is_la: 0, err: 1, chk_data: 0, data: '0});
        while (!got && t < 60) begin
            @(negedge clk); t++;
            if (rf_req_o) req_n++;
            if (wb_ack_o) begin
                got = 1;
                e = exp_q.pop_front();
                n_checks++;
                if (wb_err_o !== e.err)
                    $display("FAIL timeout_err: got %b want %b", wb_err_o, e.err);
                else n_pass++;
                wb_valid_i = 0;
            end
        end
        n_checks++;
        if (req_n !== 16 || !got)
            $display("FAIL timeout_len: got %0d req cycles ack=%b want 16 ack=1", req_n, got);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL timeout_idle: got busy=%b want 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_err_abort();
        int t = 0, acks = 0, req_n = 0;
        exp_t e;
        rf_lat = 2; rf_err_cfg = 1; rf_data_cfg = 32'h0000BEEF;
        @(negedge clk);
        la_req_i = 1; la_we_i = 0; la_addr_i = 3;
        exp_q.push_back('{is_la: 1, err: 1, chk_data: 1, data: 32'h0000BEEF});
        while (!la_done_o && t < 40) begin
            @(negedge clk); t++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({la_done_o, la_err_o, la_rdata_o} !== {1'b1, e.err, e.data})
            $display("FAIL la_ecc_err: got done=%b err=%b rdata=%h want done=1 err=%b rdata=%h",
                     la_done_o, la_err_o, la_rdata_o, e.err, e.data);
        else n_pass++;
        la_req_i = 0;
        @(negedge clk);
        rf_lat = 5; rf_err_cfg = 0;
        wb_valid_i = 1; wb_we_i = 1; wb_addr_i = 6; wb_wdata_i = 32'h66;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rf_req_o) req_n++;
            if (req_n == 2) wb_valid_i = 0;
            if (wb_ack_o) acks++;
        end
        n_checks++;
        if (acks !== 0) $display("FAIL wb_abort_ack: got %0d acks want 0", acks);
        else n_pass++;
        n_checks++;
        if (req_n !== 5 || busy_o !== 1'b0)
            $display("FAIL wb_abort_complete: got req=%0d busy=%b want req=5 busy=0",
                     req_n, busy_o);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int t = 0, req_n = 0;
        bit got = 0;
        exp_t e;
        rf_lat = 0; rf_err_cfg = 0;
        @(negedge clk);
        la_req_i = 1; la_we_i = 1; la_addr_i = 3; la_wdata_i = 32'h33;
        repeat (3) @(negedge clk);
        #2 rst_i = 1;
        #1;
        n_checks++;
        if ({rf_req_o, busy_o} !== 2'b00)
            $display("FAIL async_rst_wait: got req,busy=%b want 00", {rf_req_o, busy_o});
        else n_pass++;
        la_req_i = 0;
        @(negedge clk);
        rst_i = 0;
        rf_lat = 1; rf_data_cfg = 32'h0BADF00D;
        @(negedge clk);
        la_req_i = 1; la_we_i = 0; la_addr_i = 8;
        while (!la_done_o && t < 40) begin
            @(negedge clk); t++;
        end
        #2 rst_i = 1;
        #1;
        n_checks++;
        if ({la_done_o, busy_o} !== 2'b00)
            $display("FAIL async_rst_hold: got done,busy=%b want 00", {la_done_o, busy_o});
        else n_pass++;
        la_req_i = 0;
        @(negedge clk);
        rst_i = 0;
        @(negedge clk);
        wb_valid_i = 1; wb_we_i = 1; wb_addr_i = 4; wb_wdata_i = 32'h44;
        exp_q.push_back('{is_la: 0, err: 0, chk_data: 1, data: '0});
        t = 0;
        while (!got && t < 40) begin
            @(negedge clk); t++;
            if (rf_req_o) req_n++;
            if (wb_ack_o) begin
                got = 1;
                e = exp_q.pop_front();
                n_checks++;
                if ({wb_err_o, wb_rdata_o, grant_o} !== {e.err, e.data, 1'b0})
                    $display("FAIL post_rst_resp: got err=%b rdata=%h grant=%b want err=%b rdata=%h grant=0",
                             wb_err_o, wb_rdata_o, grant_o, e.err, e.data);
                else n_pass++;
                wb_valid_i = 0;
            end
        end
        n_checks++;
        if (!got || req_n !== 1)
            $display("FAIL post_rst_ack: got ack=%b req=%0d want ack=1 req=1", got, req_n);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_wb_write();
        test_la_read();
        test_tie();
        test_timeout();
        test_err_abort();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
